// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter. Sends one command byte to the
//               keyboard over the shared open-drain clock/data lines and
//               reports completion plus whether the device acknowledged.
// Ports       : clock50                 - system clock, all logic on posedge
//               reset                   - asynchronous active-high reset
//               send / tx_byte          - request pulse and byte to transmit
//               keyboard_clk/_data      - raw PS/2 line levels
//               keyboard_*_drive_low    - 1 = pull the line low, 0 = release
//               busy / rx_inhibit       - transmission in progress
//               done / ack_ok           - completion pulse, device ACK seen
//               error                   - timeout abort pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       keyboard_clk,
  input  logic       keyboard_data,
  output logic       keyboard_clk_drive_low,
  output logic       keyboard_data_drive_low,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                state;
  logic                  clk_meta, clk_sync;
  logic                  data_meta, data_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt;
  logic                  fall;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            bit_idx;
  logic [8:0]            frame_bits;   // {parity, data}
  logic                  ack_seen;

  // rx_inhibit mirrors the registered busy flag.
  assign rx_inhibit = busy;

  // Input conditioning. Synchronizers and filter history clear to the idle
  // (high) line level so that leaving reset never produces a spurious fall.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_hist  <= '1;
      clk_filt  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= keyboard_clk;
      clk_sync  <= clk_meta;
      data_meta <= keyboard_data;
      data_sync <= data_meta;
      clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync};
      fall      <= 1'b0;
      if (&clk_hist) begin
        clk_filt <= 1'b1;
      end else if (~|clk_hist) begin
        clk_filt <= 1'b0;
        fall     <= clk_filt;   // pulse only on the 1 -> 0 transition
      end
    end
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      keyboard_clk_drive_low  <= 1'b0;
      keyboard_data_drive_low <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      ack_ok                  <= 1'b0;
      error                   <= 1'b0;
      cnt                     <= '0;
      bit_idx                 <= '0;
      frame_bits              <= '0;
      ack_seen                <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          keyboard_clk_drive_low  <= 1'b0;
          keyboard_data_drive_low <= 1'b0;
          if (send) begin
            frame_bits             <= {~^tx_byte, tx_byte};
            ack_ok                 <= 1'b0;
            busy                   <= 1'b1;
            cnt                    <= '0;
            keyboard_clk_drive_low <= 1'b1;
            state                  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            keyboard_data_drive_low <= 1'b1;   // start bit while clock still held
            state                   <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          keyboard_clk_drive_low <= 1'b0;
          cnt                    <= '0;
          bit_idx                <= '0;
          state                  <= BITS;
        end
        BITS, ACK, WAIT_IDLE: begin
          if (!fall && cnt == TIMEOUT_LAST) begin
            keyboard_clk_drive_low  <= 1'b0;
            keyboard_data_drive_low <= 1'b0;
            busy                    <= 1'b0;
            error                   <= 1'b1;
            state                   <= IDLE;
          end else begin
            cnt <= fall ? '0 : cnt + 1'b1;
            case (state)
              BITS: begin
                // New data goes out just after the device's falling edge so it
                // is stable well before the device samples on its rising edge.
                if (fall) begin
                  if (bit_idx == 4'd9) begin
                    keyboard_data_drive_low <= 1'b0;   // stop bit: release
                    state                   <= ACK;
                  end else begin
                    keyboard_data_drive_low <= ~frame_bits[bit_idx];
                    bit_idx                 <= bit_idx + 1'b1;
                  end
                end
              end
              ACK: begin
                if (fall) begin
                  ack_seen <= ~data_sync;
                  state    <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                  done   <= 1'b1;
                  ack_ok <= ack_seen;
                  busy   <= 1'b0;
                  state  <= IDLE;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx. A behavioural PS/2
//               keyboard model clocks frames out of the host and compares the
//               received bits with the frame expected from the byte value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INHIBIT_CYCLES = 60;
  localparam int TIMEOUT_CYCLES = 3000;
  localparam int FILTER_LEN     = 8;

  logic       clock50 = 1'b0;
  logic       reset   = 1'b1;
  logic       send    = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       keyboard_clk, keyboard_data;
  logic       keyboard_clk_drive_low, keyboard_data_drive_low;
  logic       busy, rx_inhibit, done, ack_ok, error;

  // Device-side pull-downs; the lines are wired-AND of all drivers.
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low   = 1'b0;
  assign keyboard_clk  = ~(keyboard_clk_drive_low | dev_clk_low | glitch_low);
  assign keyboard_data = ~(keyboard_data_drive_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) dut (
    .clock50                 (clock50),
    .reset                   (reset),
    .send                    (send),
    .tx_byte                 (tx_byte),
    .keyboard_clk            (keyboard_clk),
    .keyboard_data           (keyboard_data),
    .keyboard_clk_drive_low  (keyboard_clk_drive_low),
    .keyboard_data_drive_low (keyboard_data_drive_low),
    .busy                    (busy),
    .rx_inhibit              (rx_inhibit),
    .done                    (done),
    .ack_ok                  (ack_ok),
    .error                   (error)
  );

  always #10 clock50 = ~clock50;

  int errors = 0;
  int checks = 0;

  // Event monitor (written only here, read by the stimulus block).
  int       done_cnt = 0;
  int       err_cnt  = 0;
  int       viol_cnt = 0;
  logic     ack_at_done   = 1'b0;
  logic     busy_at_done  = 1'b1;
  logic [1:0] lines_at_done = 2'b00;
  logic     prev_dl  = 1'b0;
  logic     in_frame = 1'b0;

  always @(negedge clock50) begin
    if (done) begin
      done_cnt++;
      ack_at_done   = ack_ok;
      busy_at_done  = busy;
      lines_at_done = {keyboard_clk, keyboard_data};
    end
    if (error) err_cnt++;
    // Host must only move data while the clock line is low.
    if (in_frame && keyboard_clk && (keyboard_data_drive_low !== prev_dl)) viol_cnt++;
    prev_dl = keyboard_data_drive_low;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock50);
  endtask

  // Reference frame as the device sees it on falling edges 1..10:
  // d0..d7, odd parity, stop(1).
  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic start_frame(input logic [7:0] b, input bit extra_send);
    int low_cnt;
    @(negedge clock50);
    tx_byte = b;
    send    = 1'b1;
    @(negedge clock50);
    send = 1'b0;
    check("busy_on_send", busy, 1);
    check("rx_inhibit_on_send", rx_inhibit, 1);
    check("ack_cleared_on_send", ack_ok, 0);
    low_cnt = 0;
    while (keyboard_clk_drive_low === 1'b1 && low_cnt < INHIBIT_CYCLES + 100) begin
      if (extra_send && low_cnt == 10) begin
        tx_byte = 8'h55;
        send    = 1'b1;
      end else if (extra_send && low_cnt == 11) begin
        send    = 1'b0;
        tx_byte = b;
      end
      low_cnt++;
      @(negedge clock50);
    end
    check("inhibit_length", (low_cnt >= INHIBIT_CYCLES) && (low_cnt < INHIBIT_CYCLES + 100), 1);
    check("start_bit_drive", keyboard_data_drive_low, 1);
    check("start_bit_lines", {keyboard_clk, keyboard_data}, 2'b10);
  endtask

  task automatic device_clocks(input int n_edges, input int half, input bit do_ack,
                               input bit glitch, output logic [9:0] got);
    got = '0;
    wait_cycles(10);
    in_frame = 1'b1;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && do_ack) begin
        dev_data_low = 1'b1;
        wait_cycles(2);
      end
      dev_clk_low = 1'b1;
      wait_cycles(half);
      if (k <= 10) got[k-1] = keyboard_data;   // sampled at the rising edge
      dev_clk_low = 1'b0;
      if (glitch && k == 3) begin
        wait_cycles(half / 2);
        glitch_low = 1'b1;
        wait_cycles(3);
        glitch_low = 1'b0;
        wait_cycles(half - half / 2 - 3);
      end else begin
        wait_cycles(half);
      end
      if (k == 11) dev_data_low = 1'b0;
    end
    in_frame = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input int half, input bit do_ack,
                           input bit extra_send, input bit glitch);
    logic [9:0] got, exp;
    int d0, e0, v0, n;
    exp = expected_frame(b);
    d0 = done_cnt;
    e0 = err_cnt;
    v0 = viol_cnt;
    start_frame(b, extra_send);
    device_clocks(11, half, do_ack, glitch, got);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      n++;
      @(negedge clock50);
    end
    wait_cycles(3);
    check("frame_bits", got, exp);
    check("device_parity_odd", $countones(got[8:0]) % 2, 1);
    check("done_pulses", done_cnt - d0, 1);
    check("error_pulses", err_cnt - e0, 0);
    check("ack_ok_at_done", ack_at_done, do_ack);
    check("busy_at_done", busy_at_done, 0);
    check("lines_high_at_done", lines_at_done, 2'b11);
    check("data_change_on_high_clock", viol_cnt - v0, 0);
    check("ack_ok_holds", ack_ok, do_ack);
    check("idle_released", {keyboard_clk_drive_low, keyboard_data_drive_low, busy, rx_inhibit}, 0);
  endtask

  initial begin
    logic [9:0] got;
    int d0, e0, n;

    // Reset state
    wait_cycles(3);
    check("reset_outputs",
          {keyboard_clk_drive_low, keyboard_data_drive_low, busy, rx_inhibit, done, ack_ok, error}, 0);
    reset = 1'b0;
    wait_cycles(20);

    // Directed frames
    run_frame(8'hED, 40, 1'b1, 1'b0, 1'b0);
    run_frame(8'hF4, 35, 1'b1, 1'b0, 1'b0);
    run_frame(8'h00, 50, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, 40, 1'b0, 1'b0, 1'b0);   // no ACK: still completes
    run_frame(8'h96, 40, 1'b1, 1'b1, 1'b1);   // ignored 2nd send + clock glitch

    // Randomized frames
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom_range(0, 255)), int'($urandom_range(30, 60)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Timeout: device stops clocking after edge 4
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'hFF, 1'b0);
    device_clocks(4, 40, 1'b0, 1'b0, got);
    check("timeout_first_bits", got[3:0], 4'hF);
    n = 0;
    while (err_cnt == e0 && n < TIMEOUT_CYCLES + 500) begin
      n++;
      @(negedge clock50);
    end
    check("timeout_latency", (n >= TIMEOUT_CYCLES - 100) && (n <= TIMEOUT_CYCLES + 100), 1);
    wait_cycles(5);
    check("timeout_error_pulses", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_released", {keyboard_clk_drive_low, keyboard_data_drive_low, busy, rx_inhibit}, 0);

    // Reset in the middle of the bit phase
    start_frame(8'hED, 1'b0);
    device_clocks(5, 40, 1'b0, 1'b0, got);
    @(negedge clock50);
    check("pre_reset_busy_data", {busy, keyboard_data_drive_low}, 2'b11);
    reset = 1'b1;
    #1;
    check("reset_mid_frame",
          {keyboard_clk_drive_low, keyboard_data_drive_low, busy, rx_inhibit, done, error}, 0);
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    run_frame(8'hED, 45, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
